// File: rtl/fractal_sync_mp_rsp_q.sv
// ---------------------------------------------------------------------------
// fractal_sync_mp_rsp_q
//
// Purpose: per-port response queues that sit behind the multi-port barrier
// CAM. When a port's check hits a line already present in the CAM, the
// barrier is complete. The signature and the merged back-routing mask
// (stored CAM mask OR the requester's own mask) are queued so that the
// response can be sent back to every participant at the consumer's pace.
// Each port has its own independent circular buffer.
//
// Ports (all per-port signals are indexed 0..N_PORTS-1):
//   clk_i, rst_i      clock (rising edge) and async active-high reset
//   check_i           port issued a CAM check this cycle
//   sig_valid_i       port signature is valid
//   sig_i             port signature as seen by the CAM
//   req_sd_i          requester's own source/destination mask
//   present_i         CAM present output (combinational) for the port
//   cam_sd_i          CAM stored back-routing mask for the port
//   rsp_valid_o       queue head valid
//   rsp_ready_i       consumer accepts the head
//   rsp_sig_o         head signature (0 when empty)
//   rsp_sd_o          head back-routing mask (0 when empty)
//   full_o            queue holds DEPTH entries (upstream stall hint)
//   overflow_o        sticky: a completion was dropped on a full queue
// ---------------------------------------------------------------------------

package fractal_sync_pkg;
  localparam int unsigned SD_WIDTH = 2;
endpackage

module fractal_sync_mp_rsp_q #(
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned SIG_WIDTH = 1,
  parameter int unsigned SD_WIDTH  = fractal_sync_pkg::SD_WIDTH,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [N_PORTS-1:0]   check_i,
  input  logic [N_PORTS-1:0]   sig_valid_i,
  input  logic [SIG_WIDTH-1:0] sig_i       [N_PORTS],
  input  logic [SD_WIDTH-1:0]  req_sd_i    [N_PORTS],
  input  logic [N_PORTS-1:0]   present_i,
  input  logic [SD_WIDTH-1:0]  cam_sd_i    [N_PORTS],
  output logic [N_PORTS-1:0]   rsp_valid_o,
  input  logic [N_PORTS-1:0]   rsp_ready_i,
  output logic [SIG_WIDTH-1:0] rsp_sig_o   [N_PORTS],
  output logic [SD_WIDTH-1:0]  rsp_sd_o    [N_PORTS],
  output logic [N_PORTS-1:0]   full_o,
  output logic [N_PORTS-1:0]   overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Pointer wrap relies on natural overflow of AW-bit counters, so DEPTH
  // must be a power of two; a single-entry queue is not supported.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $fatal(1, "fractal_sync_mp_rsp_q: DEPTH must be a power of 2 and >= 2");
  end

  typedef struct packed {
    logic [SIG_WIDTH-1:0] sig;
    logic [SD_WIDTH-1:0]  sd;
  } entry_t;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    entry_t        mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic          head_valid;
    logic          completion;
    logic          pop;
    logic          push;
    logic          drop;

    assign head_valid = (count != '0);
    assign completion = check_i[p] & sig_valid_i[p] & present_i[p];
    assign pop        = head_valid & rsp_ready_i[p];
    // A full queue can still take a completion if the head leaves in the
    // same cycle; the slot being freed is reused by the write pointer.
    assign push       = completion & ((count != DEPTH_C) | pop);
    assign drop       = completion & ~push;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
        ovf   <= 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end else begin
        if (push) begin
          mem[wptr].sig <= sig_i[p];
          mem[wptr].sd  <= cam_sd_i[p] | req_sd_i[p];
          wptr          <= wptr + AW'(1);
        end
        if (pop) begin
          rptr <= rptr + AW'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        if (drop) begin
          ovf <= 1'b1;
        end
      end
    end

    // Outputs come only from registered state, so the event inputs have no
    // combinational path to the response side.
    assign rsp_valid_o[p] = head_valid;
    assign rsp_sig_o[p]   = head_valid ? mem[rptr].sig : '0;
    assign rsp_sd_o[p]    = head_valid ? mem[rptr].sd  : '0;
    assign full_o[p]      = (count == DEPTH_C);
    assign overflow_o[p]  = ovf;
  end

endmodule

// File: doc/fractal_sync_mp_rsp_q.md
FRACTAL_SYNC_MP_RSP_Q -- requirements
Module: fractal_sync_mp_rsp_q

Interface
REQ-001 The block SHALL have parameter N_PORTS, default 2, giving the number of independent ports, each with its own queue.
REQ-002 The block SHALL have parameter SIG_WIDTH, default 1, giving the barrier signature width.
REQ-003 The block SHALL have parameter SD_WIDTH, default fractal_sync_pkg::SD_WIDTH, giving the source/destination back-routing mask width.
REQ-004 The block SHALL have parameter DEPTH, default 4, giving the queue entries per port; DEPTH is a power of 2 and at least 2, and an elaboration-time fatal assertion SHALL enforce this.
REQ-005 clk_i  input  1  the single clock; all state SHALL be clocked on its rising edge.
REQ-006 rst_i  input  1  reset; asynchronous, active-high.
REQ-007 check_i[N_PORTS]  input  1 each  the port issued a check to the multi-port CAM this cycle.
REQ-008 sig_valid_i[N_PORTS]  input  1 each  the port's signature is valid.
REQ-009 sig_i[N_PORTS]  input  SIG_WIDTH each  the port's signature, as presented to the CAM.
REQ-010 req_sd_i[N_PORTS]  input  SD_WIDTH each  the requester's own source/destination mask.
REQ-011 present_i[N_PORTS]  input  1 each  the CAM's asynchronous present output for the port.
REQ-012 cam_sd_i[N_PORTS]  input  SD_WIDTH each  the CAM's stored back-routing mask for the port.
REQ-013 rsp_valid_o[N_PORTS]  output  1 each  the port's queue head is valid.
REQ-014 rsp_ready_i[N_PORTS]  input  1 each  the consumer accepts the head.
REQ-015 rsp_sig_o[N_PORTS]  output  SIG_WIDTH each  the head entry's signature.
REQ-016 rsp_sd_o[N_PORTS]  output  SD_WIDTH each  the head entry's back-routing mask.
REQ-017 full_o[N_PORTS]  output  1 each  the port's queue holds DEPTH entries; this is the upstream stall hint.
REQ-018 overflow_o[N_PORTS]  output  1 each  sticky flag: a completion was dropped.

Function
REQ-019 A completion event on port i SHALL be check_i[i] & sig_valid_i[i] & present_i[i], evaluated combinationally in the same cycle the CAM frees its line.
REQ-020 On a completion event, the entry {sig_i[i], cam_sd_i[i] | req_sd_i[i]} SHALL be pushed into queue i at the next rising edge.
REQ-021 check_i with present_i low (first arrival), and set_i-only traffic, SHALL push nothing.
REQ-022 Each queue SHALL be a circular buffer with a read pointer and a write pointer of $clog2(DEPTH) bits each, wrapping modulo DEPTH, plus a counter of $clog2(DEPTH)+1 bits.
REQ-023 rsp_valid_o[i] SHALL equal (count[i] != 0); rsp_sig_o[i] and rsp_sd_o[i] SHALL show the entry at the read pointer, or 0 when the queue is empty.
REQ-024 Push-to-visible latency SHALL be one cycle: an event in cycle k gives rsp_valid_o high in cycle k+1 when the queue was empty; there is no combinational path from the event inputs to rsp_*_o.
REQ-025 A pop SHALL occur when rsp_valid_o[i] & rsp_ready_i[i] at the rising edge; the read pointer advances and the count decrements.
REQ-026 rsp_valid_o SHALL NOT depend on rsp_ready_i; once asserted, valid and the head data SHALL remain stable until popped.
REQ-027 A simultaneous push and pop SHALL leave the count unchanged and advance both pointers.
REQ-028 A push SHALL be accepted when count < DEPTH, or when count == DEPTH and a pop occurs in the same cycle.
REQ-029 A push to a full queue with no same-cycle pop SHALL be dropped, leave the queue state unchanged, and set overflow_o[i], which then remains set until reset.
REQ-030 full_o[i] SHALL equal (count[i] == DEPTH) and be registered-derived.
REQ-031 Ports SHALL be fully independent; simultaneous events on all ports SHALL each push to their own queue in the same cycle.

Reset
REQ-032 While rst_i is high, asynchronously, all pointers, counters and stored entries SHALL go to 0, rsp_valid_o, full_o and overflow_o SHALL be 0, and rsp_sig_o and rsp_sd_o SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL discard all queued entries, with no pop observed.
REQ-034 The first push SHALL be accepted at the first rising edge after rst_i deasserts.

Verification
REQ-035 Completion with sig=1, cam_sd=2'b01, req_sd=2'b10 on port 0, ready high -> rsp_valid_o[0]=1 one cycle later with rsp_sd_o[0]=2'b11, then low the next cycle.
REQ-036 check_i=1, present_i=0 -> no push; rsp_valid_o stays 0.
REQ-037 ready low, 4 events with sig 0,1,0,1 (DEPTH=4) -> full_o=1; a 5th event -> overflow_o=1; draining yields 0,1,0,1 in order, then full_o=0 and overflow_o still 1.
REQ-038 Queue full, event with ready high in the same cycle -> pop and push both happen; count stays 4, no overflow, and order is preserved across pointer wrap.
REQ-039 Events on ports 0 and 1 in the same cycle -> both queues valid next cycle, each holding its own data.
REQ-040 rst_i pulsed with 3 entries queued -> all outputs 0 immediately (asynchronously), and queues are empty after release.
